pueo_run_sequencer: RTL and testbench
=====================================

Name: pueo_run_sequencer

Overview:
- Sequences run control from the single-cycle run command flags produced by the command decoder (do-sync, reset, stop).
- Applies a programmable SYSCLK delay before issuing sync and run-reset, holds run-reset for a fixed length, then tracks the RUNNING state.
- Arbitrates simultaneous and overlapping commands, and flags commands it drops.
- Its outputs drive the run-control inputs of the downstream trigger and readout logic.

Parameters:
DELAY_BITS, 8, width of programmable command delay.
RESET_LEN, 16, cycles run_rst_o is held high (must be >= 1).

Ports:
sysclk_i  in  1  system clock; only clock in the block.
sys_rst_n_i  in  1  reset, asynchronous assert, active-low.
rundosync_i  in  1  do-sync command flag, 1-cycle pulse.
runrst_i  in  1  run-reset command flag, 1-cycle pulse.
runstop_i  in  1  run-stop command flag, 1-cycle pulse.
delay_i  in  DELAY_BITS  command delay D in cycles; sampled only when a sync or reset is accepted.
sync_o  out  1  1-cycle sync pulse.
run_rst_o  out  1  run reset level, RESET_LEN cycles.
running_o  out  1  high while in RUNNING.
stop_o  out  1  1-cycle pulse when a stop is accepted.
cmd_dropped_o  out  1  1-cycle pulse when a command is ignored.
state_o  out  3  current state: IDLE=0, SYNC_WAIT=1, RESET_WAIT=2, RESET_HOLD=3, RUNNING=4.

Behaviour:
- Reset values: while sys_rst_n_i is low, state is IDLE, delay and hold counters are 0, and every output is 0.
- Deassertion of sys_rst_n_i is synchronous to sysclk_i.
- All outputs are registered.
- Command priority within one cycle: stop > reset > sync. Lower-priority commands in the same cycle are discarded silently; they do not pulse cmd_dropped_o.
- IDLE:
  - runrst_i: cnt <= delay_i, go to RESET_WAIT.
  - else rundosync_i: cnt <= delay_i, go to SYNC_WAIT.
  - runstop_i: no-op, no flags.
- SYNC_WAIT:
  - Each edge: if cnt == 0, sync_o <= 1 for one cycle and go to IDLE; else cnt <= cnt - 1.
  - Latency: sync_o is registered high at the (D+1)th edge after the edge that sampled the command. D=0 gives the next cycle.
  - runstop_i: abort, go to IDLE, stop_o pulse, no sync.
  - runrst_i: replaces the pending sync; cnt <= delay_i, go to RESET_WAIT.
  - rundosync_i: dropped, cmd_dropped_o pulse.
- RESET_WAIT:
  - Same countdown as SYNC_WAIT.
  - When cnt == 0: run_rst_o <= 1, hold counter <= RESET_LEN - 1, go to RESET_HOLD.
  - run_rst_o therefore rises at edge N+1+D, where N is the sampling edge.
  - runstop_i: go to IDLE, stop_o pulse.
  - runrst_i or rundosync_i: dropped, cmd_dropped_o pulse.
- RESET_HOLD:
  - When the hold counter is 0: run_rst_o <= 0, running_o <= 1, go to RUNNING. Otherwise decrement.
  - run_rst_o is high for exactly RESET_LEN cycles.
  - runstop_i: run_rst_o <= 0 next edge, go to IDLE, stop_o pulse, running_o stays 0.
  - Other commands: dropped, cmd_dropped_o pulse.
- RUNNING:
  - runstop_i: running_o <= 0, stop_o pulse, go to IDLE.
  - runrst_i: running_o <= 0, cnt <= delay_i, go to RESET_WAIT (re-arm).
  - rundosync_i: dropped, cmd_dropped_o pulse.
- Counters never wrap:
  - The delay counter stops at 0 on exit.
  - D = 2^DELAY_BITS - 1 is legal and gives the maximum latency.
- delay_i changes while a countdown is in progress have no effect on it.
- An asynchronous reset mid-operation forces IDLE immediately. run_rst_o, running_o and any pending pulse clear without waiting for the clock, and no sync or stop is emitted.

Test Plan:
- Sync with delay: D=5, rundosync_i sampled at edge 10 -> sync_o high for one cycle after edge 16, state_o returns to 0, no other outputs toggle.
- Reset hold: RESET_LEN=16, D=0, runrst_i at edge 20 -> run_rst_o high after edges 21..36 (16 cycles), running_o rises at edge 37, state_o=4.
- Abort: stop during RESET_HOLD (cycle 5 of hold) -> run_rst_o low next edge, stop_o 1-cycle pulse, running_o never asserts, state_o=0.
- Priority: in RUNNING, runstop_i and runrst_i in the same cycle -> stop wins, state IDLE, stop_o pulse, cmd_dropped_o stays 0. In IDLE, runrst_i and rundosync_i together -> RESET_WAIT, no sync_o.
- Drops: rundosync_i while RUNNING, and runrst_i during RESET_WAIT -> cmd_dropped_o pulse each time, state and counters unaffected. Reset in SYNC_WAIT with D=3 -> replaces the sync, run_rst_o rises 4 edges later, sync_o never pulses.
- Async reset: pull sys_rst_n_i low mid RESET_HOLD, asynchronous to the clock edge -> run_rst_o and state_o go to 0 without waiting for the clock. After release, D=255 sync completes in 256 edges with no counter wrap.

Source files
------------

// File: rtl/pueo_run_sequencer_if.sv
// rtl/pueo_run_sequencer_if.sv - run-command flags in, run-control outputs out
interface pueo_run_sequencer_if #(
    parameter int DELAY_BITS = 8
);
    logic                  rundosync_i;
    logic                  runrst_i;
    logic                  runstop_i;
    logic [DELAY_BITS-1:0] delay_i;
    logic                  sync_o;
    logic                  run_rst_o;
    logic                  running_o;
    logic                  stop_o;
    logic                  cmd_dropped_o;
    logic [2:0]            state_o;

    modport master (
        output rundosync_i, runrst_i, runstop_i, delay_i,
        input  sync_o, run_rst_o, running_o, stop_o, cmd_dropped_o, state_o
    );

    modport slave (
        input  rundosync_i, runrst_i, runstop_i, delay_i,
        output sync_o, run_rst_o, running_o, stop_o, cmd_dropped_o, state_o
    );
endinterface

// File: rtl/pueo_run_sequencer.sv
// rtl/pueo_run_sequencer.sv - delayed sync / run-reset sequencing and RUNNING tracking
module pueo_run_sequencer #(
    parameter int DELAY_BITS = 8,
    parameter int RESET_LEN  = 16
) (
    input  logic                 sysclk_i,
    input  logic                 sys_rst_n_i,
    pueo_run_sequencer_if.slave  bus
);
    localparam int HOLD_BITS = (RESET_LEN > 1) ? $clog2(RESET_LEN) : 1;
    localparam logic [HOLD_BITS-1:0] HOLD_INIT = HOLD_BITS'(RESET_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SYNC_WAIT  = 3'd1,
        S_RESET_WAIT = 3'd2,
        S_RESET_HOLD = 3'd3,
        S_RUNNING    = 3'd4
    } state_t;

    state_t                r_state;
    logic [DELAY_BITS-1:0] r_cnt;
    logic [HOLD_BITS-1:0]  r_hold;
    logic                  r_sync;
    logic                  r_run_rst;
    logic                  r_running;
    logic                  r_stop;
    logic                  r_dropped;

    always_ff @(posedge sysclk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_sync    <= 1'b0;
            r_run_rst <= 1'b0;
            r_running <= 1'b0;
            r_stop    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_sync    <= 1'b0;
            r_stop    <= 1'b0;
            r_dropped <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A stop with nothing pending is silently ignored.
                    if (!bus.runstop_i && bus.runrst_i) begin
                        r_cnt   <= bus.delay_i;
                        r_state <= S_RESET_WAIT;
                    end else if (!bus.runstop_i && bus.rundosync_i) begin
                        r_cnt   <= bus.delay_i;
                        r_state <= S_SYNC_WAIT;
                    end
                end
                S_SYNC_WAIT: begin
                    if (bus.runstop_i) begin
                        r_stop  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (bus.runrst_i) begin
                        r_cnt   <= bus.delay_i;
                        r_state <= S_RESET_WAIT;
                    end else begin
                        r_dropped <= bus.rundosync_i;
                        if (r_cnt == '0) begin
                            r_sync  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_RESET_WAIT: begin
                    if (bus.runstop_i) begin
                        r_stop  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_dropped <= bus.runrst_i | bus.rundosync_i;
                        if (r_cnt == '0) begin
                            r_run_rst <= 1'b1;
                            r_hold    <= HOLD_INIT;
                            r_state   <= S_RESET_HOLD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_RESET_HOLD: begin
                    if (bus.runstop_i) begin
                        r_stop    <= 1'b1;
                        r_run_rst <= 1'b0;
                        r_hold    <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_dropped <= bus.runrst_i | bus.rundosync_i;
                        if (r_hold == '0) begin
                            r_run_rst <= 1'b0;
                            r_running <= 1'b1;
                            r_state   <= S_RUNNING;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                end
                S_RUNNING: begin
                    if (bus.runstop_i) begin
                        r_stop    <= 1'b1;
                        r_running <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (bus.runrst_i) begin
                        // Re-arm: a new run reset sequence without passing through IDLE.
                        r_running <= 1'b0;
                        r_cnt     <= bus.delay_i;
                        r_state   <= S_RESET_WAIT;
                    end else begin
                        r_dropped <= bus.rundosync_i;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sync_o        = r_sync;
    assign bus.run_rst_o     = r_run_rst;
    assign bus.running_o     = r_running;
    assign bus.stop_o        = r_stop;
    assign bus.cmd_dropped_o = r_dropped;
    assign bus.state_o       = r_state;
endmodule

// File: tb/tb_pueo_run_sequencer.sv
// tb/tb_pueo_run_sequencer.sv - scoreboard bench with deadline-based reference model
module tb_pueo_run_sequencer;
    localparam int DB = 8;
    localparam int RL = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pueo_run_sequencer_if #(.DELAY_BITS(DB)) bus ();

    pueo_run_sequencer #(.DELAY_BITS(DB), .RESET_LEN(RL)) dut (
        .sysclk_i    (clk),
        .sys_rst_n_i (rst_n),
        .bus         (bus)
    );

    typedef struct packed {
        logic       sync;
        logic       rr;
        logic       run;
        logic       stop;
        logic       drop;
        logic [2:0] st;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    // Model keeps absolute edge deadlines instead of down-counters.
    int     m_mode = 0;
    longint m_due  = 0;
    logic   m_rr   = 1'b0;
    logic   m_run  = 1'b0;

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        logic st, rr, sy;
        int   d;
        cyc++;
        st = bus.runstop_i;
        rr = bus.runrst_i;
        sy = bus.rundosync_i;
        d  = int'(bus.delay_i);
        e  = '0;
        if (!rst_n) begin
            m_mode = 0;
            m_rr   = 1'b0;
            m_run  = 1'b0;
            m_due  = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (!st && rr) begin m_mode = 2; m_due = cyc + 1 + d; end
                    else if (!st && sy) begin m_mode = 1; m_due = cyc + 1 + d; end
                end
                1: begin
                    if (st) begin m_mode = 0; e.stop = 1'b1; end
                    else if (rr) begin m_mode = 2; m_due = cyc + 1 + d; end
                    else begin
                        e.drop = sy;
                        if (cyc == m_due) begin e.sync = 1'b1; m_mode = 0; end
                    end
                end
                2: begin
                    if (st) begin m_mode = 0; e.stop = 1'b1; end
                    else begin
                        e.drop = rr | sy;
                        if (cyc == m_due) begin m_rr = 1'b1; m_mode = 3; m_due = cyc + RL; end
                    end
                end
                3: begin
                    if (st) begin m_mode = 0; m_rr = 1'b0; e.stop = 1'b1; end
                    else begin
                        e.drop = rr | sy;
                        if (cyc == m_due) begin m_rr = 1'b0; m_run = 1'b1; m_mode = 4; end
                    end
                end
                default: begin
                    if (st) begin m_mode = 0; m_run = 1'b0; e.stop = 1'b1; end
                    else if (rr) begin m_run = 1'b0; m_mode = 2; m_due = cyc + 1 + d; end
                    else e.drop = sy;
                end
            endcase
            e.rr  = m_rr;
            e.run = m_run;
            e.st  = 3'(m_mode);
            q.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            q.delete();
            chk("reset_outputs", int'({bus.sync_o, bus.run_rst_o, bus.running_o,
                                      bus.stop_o, bus.cmd_dropped_o, bus.state_o}), 0);
        end else if (q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = q.pop_front();
            chk("sync_o",        int'(bus.sync_o),        int'(e.sync));
            chk("run_rst_o",     int'(bus.run_rst_o),     int'(e.rr));
            chk("running_o",     int'(bus.running_o),     int'(e.run));
            chk("stop_o",        int'(bus.stop_o),        int'(e.stop));
            chk("cmd_dropped_o", int'(bus.cmd_dropped_o), int'(e.drop));
            chk("state_o",       int'(bus.state_o),       int'(e.st));
        end
    end

    task automatic cmd(logic st, logic rr, logic sy, int d);
        @(negedge clk);
        bus.runstop_i   = st;
        bus.runrst_i    = rr;
        bus.rundosync_i = sy;
        bus.delay_i     = DB'(d);
        @(negedge clk);
        bus.runstop_i   = 1'b0;
        bus.runrst_i    = 1'b0;
        bus.rundosync_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.runstop_i   = 1'b0;
        bus.runrst_i    = 1'b0;
        bus.rundosync_i = 1'b0;
        bus.delay_i     = '0;
        idle(3);
        release_reset();
        idle(3);

        cmd(0, 0, 1, 5);  idle(10);
        cmd(0, 1, 0, 0);  idle(20);
        cmd(0, 0, 1, 7);  idle(2);
        cmd(1, 1, 0, 0);  idle(3);

        cmd(0, 1, 0, 0);  idle(4);
        cmd(1, 0, 0, 0);  idle(3);

        cmd(0, 1, 1, 2);
        cmd(0, 1, 0, 9);  idle(25);
        cmd(1, 0, 0, 0);  idle(2);

        cmd(0, 0, 1, 3);
        cmd(0, 1, 0, 3);  idle(8);
        cmd(1, 0, 0, 0);  idle(2);

        cmd(0, 1, 0, 0);  idle(8);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_run_rst", int'(bus.run_rst_o), 0);
        chk("async_state",   int'(bus.state_o),   0);
        chk("async_running", int'(bus.running_o), 0);
        idle(2);
        release_reset();

        cmd(0, 0, 1, 255);
        bus.delay_i = 8'd17;
        idle(262);

        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            bus.runstop_i   = ($urandom_range(0, 24) == 0);
            bus.runrst_i    = ($urandom_range(0, 12) == 0);
            bus.rundosync_i = ($urandom_range(0, 6) == 0);
            bus.delay_i     = ($urandom_range(0, 19) == 0) ? DB'($urandom_range(0, 255))
                                                            : DB'($urandom_range(0, 6));
        end
        @(negedge clk);
        bus.runstop_i   = 1'b0;
        bus.runrst_i    = 1'b0;
        bus.rundosync_i = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
